ws2812_chain_tx: RTL and testbench
==================================

# ws2812_chain_tx

- Parametrised WS2812 chain transmitter for a string of `NUM_LEDS` pixels.
- Holds an internal pixel buffer written by the host and applies a global brightness scale.
- On `start`, serialises the whole frame as contiguous return-to-zero bits and ends it with the latch/reset low period.
- Successor to the single-pixel RGB control + RZ encoder pair: it replaces both with one buffered, configurable block that drives the `RZ_data` pin directly.

## Interface
Parameters:
- `NUM_LEDS`, 8, pixels in chain (≥1); `AW = max(1, $clog2(NUM_LEDS))`
- `T0H_CYC`, 18, high cycles for a 0 bit
- `T1H_CYC`, 35, high cycles for a 1 bit
- `TBIT_CYC`, 63, total cycles per bit; must satisfy T0H_CYC < T1H_CYC < TBIT_CYC
- `RESET_CYC`, 4000, low cycles of latch period (80 µs @ 50 MHz)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `wr_en`  in  1  pixel buffer write strobe
- `wr_addr`  in  AW  pixel index, 0 = first LED on wire; values ≥ NUM_LEDS ignored
- `wr_data`  in  24  pixel colour {R[23:16], G[15:8], B[7:0]}
- `brightness`  in  8  global scale, sampled on accepted `start`
- `start`  in  1  frame request, level-sampled each cycle
- `busy`  out  1  high from accepted start until end of latch
- `frame_done`  out  1  one-cycle pulse at end of latch
- `RZ_data`  out  1  serial line to first LED

## Operation
- Reset values: `RZ_data`=0, `busy`=0, `frame_done`=0, FSM=IDLE, counters 0. Pixel buffer is not cleared by reset.
- FSM states: IDLE, LOAD, BIT, LATCH.
  - IDLE: `start`=1 → LOAD; latch `brightness`; pixel index := 0; issue buffer read of pixel 0. `start` in any other state is ignored.
  - LOAD (1 cycle): shift register := scaled pixel 0 in GRB order → BIT.
  - BIT: bit counter 23→0; cycle counter 0..TBIT_CYC-1.
    - `RZ_data`=1 while cycle < (bit ? T1H_CYC : T0H_CYC), else 0.
    - At cycle TBIT_CYC-1: next bit. After bit 0 of pixel k:
      - k < NUM_LEDS-1: load pixel k+1 with no gap.
      - otherwise → LATCH.
  - LATCH: `RZ_data`=0 for RESET_CYC cycles. Last cycle → IDLE with `frame_done`=1 and `busy`=0.
- Prefetch: the read for pixel k+1 is issued during pixel k. The bit period stays exactly TBIT_CYC across pixel boundaries.
- Wire order: G[7]..G[0], R[7]..R[0], B[7]..B[0], MSB first.
- Scaling, per channel: `c' = (c × (brightness+1)) >> 8`, 16-bit product, low 8 bits of the shifted result. brightness=255 passes data unchanged; brightness=0 → every c' is 0.
- Writes are allowed at any time; synchronous write, 1-cycle read latency. A pixel's value is frozen when its prefetch read is issued:
  - writes to later pixels affect the current frame;
  - writes to earlier pixels affect the next frame.
- A write and a read to the same address in the same cycle returns the old data.
- Reset mid-frame: `RZ_data` low immediately (async). The next `start` sends a complete frame from pixel 0.

## Timing
- `start` sampled high at edge E0: `busy`=1 after E0; `RZ_data` rises after E1 (LOAD).
- Frame duration, first `RZ_data` rise to `frame_done`: NUM_LEDS×24×TBIT_CYC + RESET_CYC cycles.
- `frame_done` and `busy`=0 coincide, in the IDLE-entry cycle. A `start` in that cycle is accepted (back-to-back frames).
- Output is registered; no combinational path from inputs to `RZ_data`.

## Structure
- Package `ws2812_pkg`: FSM state enum; `function scale8(c, b)`; GRB reorder function; default timing constants for 50 MHz.
- Sub-module `ws2812_pixel_ram`: NUM_LEDS×24 simple dual-port RAM, sync write, sync read, read-old-on-collision.
- Top-level glue in the design instantiates `ws2812_chain_tx` in place of the RGB control/RZ encoder pair.

## Test plan
- NUM_LEDS=2, LED0=0xFF0000, LED1=0x0000FF, brightness=255, start:
  - LED0 bits: 8×0 (18 high/45 low), then 8×1 (35/28), then 8×0.
  - LED1 bits: 16×0, then 8×1.
  - `frame_done` exactly 2×24×63+4000 cycles after first rise.
- Brightness scaling:
  - LED0=0xFFFFFF, brightness=127: every byte on wire = 0x7F.
  - brightness=0: all 48 bits are 0 bits, but the full frame length is still driven.
- Contention: `start` held high for the whole frame → one frame; a second frame begins the cycle `frame_done` pulses. `start` pulses mid-frame are ignored.
- Write timing: during pixel 0 transmission, write LED1=0x00FF00 → LED1 sent as 0xFF0000 in GRB. Same-time write to LED0 → no effect until the next frame.
- Reset mid-frame: assert `rst` at bit 30 → `RZ_data`=0, `busy`=0 immediately. The next `start` transmits the full frame from LED0 with the buffer contents intact.
- Boundary: NUM_LEDS=1 (AW=1), `wr_addr`=1 write ignored; a single 24-bit frame is followed by latch.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz timing and the colour helpers for the WS2812 chain transmitter.
package ws2812_pkg;

    localparam int PIX_W = 24;

    localparam int DEF_T0H_CYC   = 18;
    localparam int DEF_T1H_CYC   = 35;
    localparam int DEF_TBIT_CYC  = 63;
    localparam int DEF_RESET_CYC = 4000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2,
        ST_LATCH = 2'd3
    } tx_state_e;

    // c * (b + 1) never exceeds 255 * 256, so the 16-bit product is exact.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [PIX_W-1:0] scale_pixel(input logic [PIX_W-1:0] rgb, input logic [7:0] b);
        return {scale8(rgb[23:16], b), scale8(rgb[15:8], b), scale8(rgb[7:0], b)};
    endfunction

    function automatic logic [PIX_W-1:0] grb_order(input logic [PIX_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel buffer: simple dual-port RAM with synchronous write and a registered read port.
// A read and write to the same address in one cycle returns the previous contents.
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    localparam logic [AW:0] NUM_W = (AW + 1)'(NUM_LEDS);

    logic [PIX_W-1:0] mem_q [2**AW];
    logic [PIX_W-1:0] rd_data_q;
    logic [PIX_W-1:0] rd_data_d;
    logic             wr_ok_s;

    // Write qualification and next read-register value
    always_comb begin
        wr_ok_s = wr_en && ({1'b0, wr_addr} < NUM_W);
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Storage array; addresses beyond the chain length are dropped
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812_chain_tx.sv
// Buffered WS2812 chain transmitter: scales each stored pixel by a global brightness and
// streams the whole chain as contiguous return-to-zero bits followed by the latch period.
module ws2812_chain_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int TBIT_CYC  = DEF_TBIT_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC,
    parameter int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [7:0]    brightness,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          RZ_data
);

    localparam int CNT_MAX = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] T0H_L     = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L     = CW'(T1H_CYC);
    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYC - 1);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_LEDS - 1);

    tx_state_e        state_q, state_d;
    logic [AW-1:0]    pix_q, pix_d;
    logic [4:0]       bit_q, bit_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [PIX_W-1:0] shift_q, shift_d;
    logic [7:0]       bright_q, bright_d;
    logic             rz_q, rz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rd_en_s;
    logic [AW-1:0]    rd_addr_s;
    logic [PIX_W-1:0] rd_data_s;

    ws2812_pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pix_q    <= '0;
            bit_q    <= 5'd0;
            cyc_q    <= '0;
            shift_q  <= '0;
            bright_q <= 8'd0;
            rz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            shift_q  <= shift_d;
            bright_q <= bright_d;
            rz_q     <= rz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state and bit/pixel sequencing
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        shift_d  = shift_q;
        bright_d = bright_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    bright_d = brightness;
                    pix_d    = '0;
                    bit_d    = 5'd23;
                    cyc_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_d = grb_order(scale_pixel(rd_data_s, bright_q));
                bit_d   = 5'd23;
                cyc_d   = '0;
                state_d = ST_BIT;
            end
            ST_BIT: begin
                if (cyc_q == TBIT_LAST) begin
                    cyc_d = '0;
                    if (bit_q != 5'd0) begin
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[PIX_W-2:0], 1'b0};
                    end else if (pix_q != LAST_PIX) begin
                        // Prefetched pixel is already on the read port: no gap between pixels.
                        pix_d   = pix_q + AW'(1);
                        bit_d   = 5'd23;
                        shift_d = grb_order(scale_pixel(rd_data_s, bright_q));
                    end else begin
                        state_d = ST_LATCH;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_LATCH: begin
                if (cyc_q == RST_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer reads and registered outputs derived from the next state
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = '0;
        if ((state_q == ST_IDLE) && start) begin
            rd_en_s   = 1'b1;
            rd_addr_s = '0;
        end else if ((state_q == ST_BIT) && (bit_q == 5'd0) && (cyc_q == '0) && (pix_q != LAST_PIX)) begin
            rd_en_s   = 1'b1;
            rd_addr_s = pix_q + AW'(1);
        end else begin
            rd_en_s   = 1'b0;
            rd_addr_s = '0;
        end
        rz_d   = (state_d == ST_BIT) && (cyc_d < (shift_d[PIX_W-1] ? T1H_L : T0H_L));
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
    end

    assign RZ_data    = rz_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// Randomised scoreboard bench: a wire-level decoder measures RZ_data pulses and compares each
// decoded pixel with values predicted from the colour/brightness arithmetic.
module tb_ws2812_chain_tx;

    localparam int T0H  = 18;
    localparam int T1H  = 35;
    localparam int TBIT = 63;
    localparam int RSTC = 4000;
    localparam int NA   = 2;
    localparam int NB   = 1;

    logic        clk;
    logic        rst;
    logic        wr_en_a, wr_en_b, start_a, start_b;
    logic [0:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        busy_a, done_a, rz_a;
    logic        busy_b, done_b, rz_b;

    ws2812_chain_tx #(.NUM_LEDS(NA), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .RESET_CYC(RSTC)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data),
        .brightness(brightness), .start(start_a), .busy(busy_a), .frame_done(done_a), .RZ_data(rz_a));

    ws2812_chain_tx #(.NUM_LEDS(NB), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .RESET_CYC(RSTC)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .brightness(brightness), .start(start_b), .busy(busy_b), .frame_done(done_b), .RZ_data(rz_b));

    logic [23:0] mem_a [NA];
    logic [23:0] mem_b [NB];
    logic [23:0] exp_a [$];
    logic [23:0] exp_b [$];

    int     n_chk = 0;
    int     n_pass = 0;
    longint cyc = 0;

    logic        prev_s   [2];
    bit          in_frame [2];
    int          hi_len   [2];
    int          nb       [2];
    int          npix     [2];
    longint      last_rise  [2];
    longint      first_rise [2];
    logic [23:0] acc      [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    endtask

    function automatic logic [23:0] model_px(input logic [23:0] rgb, input int b);
        int r, g, bl;
        r  = (int'(rgb[23:16]) * (b + 1)) / 256;
        g  = (int'(rgb[15:8])  * (b + 1)) / 256;
        bl = (int'(rgb[7:0])   * (b + 1)) / 256;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    // Wire decoder for one chain; pixels are popped from the expectation queue as they complete.
    task automatic mon_step(input int ch, input logic rz, input logic done, input logic r);
        logic [23:0] w;
        int qs, nl;
        bit bv;
        nl = (ch == 0) ? NA : NB;
        if (r) begin
            prev_s[ch] = 1'b0; in_frame[ch] = 1'b0; nb[ch] = 0; npix[ch] = 0; hi_len[ch] = 0;
            if (ch == 0) exp_a.delete(); else exp_b.delete();
        end else begin
            if (rz && !prev_s[ch]) begin
                if (in_frame[ch]) begin
                    chk(cyc - last_rise[ch] == longint'(TBIT), $sformatf("bit_period[%0d]", ch),
                        cyc - last_rise[ch], longint'(TBIT));
                end else begin
                    in_frame[ch] = 1'b1; first_rise[ch] = cyc; nb[ch] = 0; npix[ch] = 0;
                end
                last_rise[ch] = cyc;
                hi_len[ch] = 1;
            end else if (rz) begin
                hi_len[ch]++;
            end else if (prev_s[ch]) begin
                bv = (hi_len[ch] == T1H);
                chk(bv || (hi_len[ch] == T0H), $sformatf("bit_high_time[%0d]", ch),
                    longint'(hi_len[ch]), longint'(bv ? T1H : T0H));
                acc[ch] = {acc[ch][22:0], bv};
                nb[ch]++;
                if (nb[ch] == 24) begin
                    nb[ch] = 0;
                    npix[ch]++;
                    qs = (ch == 0) ? exp_a.size() : exp_b.size();
                    chk(qs != 0, $sformatf("pixel_avail[%0d]", ch), longint'(qs), 64'd1);
                    if (qs != 0) begin
                        if (ch == 0) w = exp_a.pop_front(); else w = exp_b.pop_front();
                        chk(acc[ch] == w, $sformatf("pixel_word[%0d]", ch), longint'(acc[ch]), longint'(w));
                    end
                end
            end
            if (done) begin
                chk(in_frame[ch], $sformatf("done_in_frame[%0d]", ch), longint'(in_frame[ch]), 64'd1);
                chk(cyc - last_rise[ch] == longint'(TBIT + RSTC), $sformatf("latch_len[%0d]", ch),
                    cyc - last_rise[ch], longint'(TBIT + RSTC));
                chk(cyc - first_rise[ch] == longint'(nl * 24 * TBIT + RSTC), $sformatf("frame_len[%0d]", ch),
                    cyc - first_rise[ch], longint'(nl * 24 * TBIT + RSTC));
                chk(npix[ch] == nl, $sformatf("frame_pixels[%0d]", ch), longint'(npix[ch]), longint'(nl));
                in_frame[ch] = 1'b0;
            end
            prev_s[ch] = rz;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            mon_step(0, rz_a, done_a, rst);
            mon_step(1, rz_b, done_b, rst);
        end
    end

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int ch, input int addr, input logic [23:0] d);
        wr_addr = addr[0:0];
        wr_data = d;
        if (ch == 0) begin
            wr_en_a = 1'b1;
            if (addr < NA) mem_a[addr] = d;
        end else begin
            wr_en_b = 1'b1;
            if (addr < NB) mem_b[addr] = d;
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic push_px(input int ch, input int k, input int b);
        if (ch == 0) exp_a.push_back(model_px(mem_a[k], b));
        else exp_b.push_back(model_px(mem_b[k], b));
    endtask

    task automatic push_frame(input int ch, input int b);
        for (int k = 0; k < ((ch == 0) ? NA : NB); k++) push_px(ch, k, b);
    endtask

    task automatic start_frame(input int ch, input int b, input bit hold);
        logic bsy, r;
        brightness = b[7:0];
        if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
        bsy = (ch == 0) ? busy_a : busy_b;
        r   = (ch == 0) ? rz_a : rz_b;
        chk(bsy == 1'b1, "busy_after_start", longint'(bsy), 64'd1);
        chk(r == 1'b0, "rz_low_in_load", longint'(r), 64'd0);
        @(posedge clk); #1;
        r = (ch == 0) ? rz_a : rz_b;
        chk(r == 1'b1, "rz_first_rise", longint'(r), 64'd1);
    endtask

    task automatic wait_done(input int ch, input int budget);
        bit seen;
        logic bsy;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            seen = (ch == 0) ? done_a : done_b;
        end
        chk(seen, "frame_done_seen", longint'(seen), 64'd1);
        if (seen) begin
            bsy = (ch == 0) ? busy_a : busy_b;
            chk(bsy == 1'b0, "busy_low_at_done", longint'(bsy), 64'd0);
        end
    endtask

    initial begin
        int b;
        rst = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        wr_addr = 1'b0; wr_data = 24'd0; brightness = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk(rz_a == 1'b0, "reset_rz_a", longint'(rz_a), 64'd0);
        chk(busy_a == 1'b0, "reset_busy_a", longint'(busy_a), 64'd0);
        chk(done_a == 1'b0, "reset_done_a", longint'(done_a), 64'd0);
        chk(rz_b == 1'b0, "reset_rz_b", longint'(rz_b), 64'd0);
        chk(busy_b == 1'b0, "reset_busy_b", longint'(busy_b), 64'd0);
        chk(done_b == 1'b0, "reset_done_b", longint'(done_b), 64'd0);
        rst = 1'b0;
        skip(2);

        // Red then blue at full brightness
        write_px(0, 0, 24'hFF0000);
        write_px(0, 1, 24'h0000FF);
        push_frame(0, 255);
        start_frame(0, 255, 1'b0);
        wait_done(0, 8000);

        // Half brightness on white, then brightness zero
        write_px(0, 0, 24'hFFFFFF);
        write_px(0, 1, 24'($urandom));
        push_frame(0, 127);
        start_frame(0, 127, 1'b0);
        wait_done(0, 8000);
        push_frame(0, 0);
        start_frame(0, 0, 1'b0);
        wait_done(0, 8000);

        // start held through the frame; writes during pixel 0
        write_px(0, 0, 24'($urandom));
        write_px(0, 1, 24'($urandom));
        push_px(0, 0, 255);
        start_frame(0, 255, 1'b1);
        skip(5 * TBIT);
        write_px(0, 1, 24'h00FF00);
        write_px(0, 0, 24'($urandom));
        push_px(0, 1, 255);
        push_frame(0, 255);
        wait_done(0, 8000);
        @(posedge clk); #1;
        chk(busy_a == 1'b1, "back_to_back_busy", longint'(busy_a), 64'd1);
        start_a = 1'b0;
        @(posedge clk); #1;
        chk(rz_a == 1'b1, "back_to_back_rise", longint'(rz_a), 64'd1);
        for (int i = 0; i < 3; i++) begin
            skip(500);
            start_a = 1'b1;
            skip(1);
            start_a = 1'b0;
        end
        wait_done(0, 8000);
        skip(20);
        chk(busy_a == 1'b0, "no_extra_frame", longint'(busy_a), 64'd0);

        // Reset around bit 30, then a complete frame with the buffer intact
        push_frame(0, 255);
        start_frame(0, 255, 1'b0);
        skip(30 * TBIT + 10);
        #1 rst = 1'b1;
        #1;
        chk(rz_a == 1'b0, "midframe_reset_rz", longint'(rz_a), 64'd0);
        chk(busy_a == 1'b0, "midframe_reset_busy", longint'(busy_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        skip(2);
        push_frame(0, 255);
        start_frame(0, 255, 1'b0);
        wait_done(0, 8000);

        // Random data and brightness
        write_px(0, 0, 24'($urandom));
        write_px(0, 1, 24'($urandom));
        b = int'($urandom_range(0, 255));
        push_frame(0, b);
        start_frame(0, b, 1'b0);
        wait_done(0, 8000);

        // Single-pixel chain: out-of-range write is ignored
        write_px(1, 0, 24'($urandom));
        write_px(1, 1, 24'($urandom));
        push_frame(1, 255);
        start_frame(1, 255, 1'b0);
        wait_done(1, 6000);
        b = int'($urandom_range(0, 255));
        push_frame(1, b);
        start_frame(1, b, 1'b0);
        wait_done(1, 6000);

        skip(10);
        chk(exp_a.size() == 0, "leftover_a", longint'(exp_a.size()), 64'd0);
        chk(exp_b.size() == 0, "leftover_b", longint'(exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
